hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the EX-stage forwarding logic and handles the hazards forwarding cannot cover: load-use, taken branch/jump redirect, multi-cycle data-memory wait and debug halt. It issues per-stage stall (hold) and flush (bubble) controls to the PC and the IFID, IDEX, EXMEM and MEMWB pipeline registers. A small FSM tracks memory-wait, halt and error conditions.

---
 rtl/hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RISC-V core.
//               Covers the hazards that EX forwarding cannot resolve:
//               load-use, taken branch/jump redirect, multi-cycle data
//               memory wait and debug halt. Drives per-stage hold/bubble
//               controls combinationally from the registered FSM state.
// Ports       : clk, rst_n (sync, active low)
//               Instruction_IFID_IDEX  - ID instruction (rs1/rs2 fields)
//               Instruction_IDEX_EXMEM - EX instruction (rd field)
//               MemRead_IDEX_EXMEM, branch_taken_EX, dmem_req_MEM,
//               dmem_ready, halt_req   - hazard sources
//               stall_PC/IFID/IDEX/EXMEM, flush_IFID/IDEX/MEMWB - controls
//               halted, mem_timeout_err - status
//               perf_*_cnt (only with HAZARD_PERF_CNT_EN) - event counters
// Macro       : HAZARD_PERF_CNT_EN adds the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       Instruction_IFID_IDEX,
   input  logic [31:0]       Instruction_IDEX_EXMEM,
   input  logic              MemRead_IDEX_EXMEM,
   input  logic              branch_taken_EX,
   input  logic              dmem_req_MEM,
   input  logic              dmem_ready,
   input  logic              halt_req,
   output logic              stall_PC,
   output logic              stall_IFID,
   output logic              stall_IDEX,
   output logic              stall_EXMEM,
   output logic              flush_IFID,
   output logic              flush_IDEX,
   output logic              flush_MEMWB,
   output logic              halted,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0]  perf_loaduse_cnt,
   output logic [CNT_W-1:0]  perf_memwait_cnt,
   output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
   output logic              mem_timeout_err
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2,
      ERROR    = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
   logic        r_halt_pend, w_halt_pend_nxt;
   logic        r_err, w_err_nxt;

   logic [4:0]  w_ex_rd, w_id_rs1, w_id_rs2;
   logic        w_load_use, w_mem_wait;
   logic        w_unused;

   assign w_ex_rd  = Instruction_IDEX_EXMEM[11:7];
   assign w_id_rs1 = Instruction_IFID_IDEX[19:15];
   assign w_id_rs2 = Instruction_IFID_IDEX[24:20];
   assign w_unused = &{Instruction_IDEX_EXMEM[31:12], Instruction_IDEX_EXMEM[6:0],
                       Instruction_IFID_IDEX[31:25], Instruction_IFID_IDEX[14:0]};

   // No opcode decode: both source fields are always compared, so an
   // instruction that does not really read rs2 may take a harmless bubble.
   assign w_load_use = MemRead_IDEX_EXMEM && (w_ex_rd != 5'd0) &&
                       ((w_ex_rd == w_id_rs1) || (w_ex_rd == w_id_rs2));
   assign w_mem_wait = dmem_req_MEM && !dmem_ready;

   assign mem_timeout_err = r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_wait_cnt  <= 16'd0;
         r_halt_pend <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_halt_pend <= w_halt_pend_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_halt_pend_nxt = r_halt_pend;
      w_err_nxt       = r_err;
      stall_PC        = 1'b0;
      stall_IFID      = 1'b0;
      stall_IDEX      = 1'b0;
      stall_EXMEM     = 1'b0;
      flush_IFID      = 1'b0;
      flush_IDEX      = 1'b0;
      flush_MEMWB     = 1'b0;
      halted          = 1'b0;

      if (!rst_n) begin
         // Keep bubbles flowing into the pipeline while reset is held.
         flush_IFID  = 1'b1;
         flush_IDEX  = 1'b1;
         flush_MEMWB = 1'b1;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mem_wait) begin
                  {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM} = 4'hF;
                  flush_MEMWB    = 1'b1;
                  w_state_nxt    = MEM_WAIT;
                  w_wait_cnt_nxt = 16'd1;
               end else if (halt_req) begin
                  {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM} = 4'hF;
                  flush_MEMWB = 1'b1;
                  w_state_nxt = HALTED;
               end else if (branch_taken_EX) begin
                  // ID holds a wrong-path instruction, so any load-use
                  // match against it is irrelevant.
                  flush_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end else if (w_load_use) begin
                  // The bubble reaching EX clears the match next cycle.
                  stall_PC   = 1'b1;
                  stall_IFID = 1'b1;
                  flush_IDEX = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (halt_req) begin
                  w_halt_pend_nxt = 1'b1;
               end
               if (dmem_ready) begin
                  w_state_nxt     = (r_halt_pend || halt_req) ? HALTED : RUN;
                  w_wait_cnt_nxt  = 16'd0;
                  w_halt_pend_nxt = 1'b0;
               end else begin
                  {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM} = 4'hF;
                  flush_MEMWB = 1'b1;
                  if (r_wait_cnt == TIMEOUT_VAL) begin
                     w_state_nxt = ERROR;
                     w_err_nxt   = 1'b1;
                  end else if (r_wait_cnt != 16'hFFFF) begin
                     w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                  end
               end
            end
            HALTED: begin
               halted = 1'b1;
               {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM} = 4'hF;
               flush_MEMWB = 1'b1;
               if (!halt_req) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM} = 4'hF;
               flush_MEMWB = 1'b1;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic w_inc_lu, w_inc_mw, w_inc_br;

   // Mirror the RUN priority chain so each event counts only when it wins.
   assign w_inc_lu = (r_state == RUN) && !w_mem_wait && !halt_req &&
                     !branch_taken_EX && w_load_use;
   assign w_inc_br = (r_state == RUN) && !w_mem_wait && !halt_req && branch_taken_EX;
   assign w_inc_mw = ((r_state == RUN) && w_mem_wait) ||
                     ((r_state == MEM_WAIT) && !dmem_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_loaduse_cnt <= '0;
         perf_memwait_cnt <= '0;
         perf_flush_cnt   <= '0;
      end else begin
         if (w_inc_lu && perf_loaduse_cnt != CNT_MAX) perf_loaduse_cnt <= perf_loaduse_cnt + 1'b1;
         if (w_inc_mw && perf_memwait_cnt != CNT_MAX) perf_memwait_cnt <= perf_memwait_cnt + 1'b1;
         if (w_inc_br && perf_flush_cnt   != CNT_MAX) perf_flush_cnt   <= perf_flush_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
//               Each driven cycle pushes its expected control vector; the
//               vector is popped and compared mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_id, inst_ex;
   logic        mem_read, br_taken, dmem_req, dmem_ready, halt_req;
   logic        stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
   logic        flush_IFID, flush_IDEX, flush_MEMWB, halted, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_lu, perf_mw, perf_br;
`endif

   int total = 0;
   int bad   = 0;

   // Expected vector: {sPC,sIFID,sIDEX,sEXMEM,fIFID,fIDEX,fMEMWB,halted,err}
   localparam logic [8:0] E_IDLE  = 9'b0000_0000_0;
   localparam logic [8:0] E_RST   = 9'b0000_1110_0;
   localparam logic [8:0] E_LU    = 9'b1100_0100_0;
   localparam logic [8:0] E_BR    = 9'b0000_1100_0;
   localparam logic [8:0] E_STALL = 9'b1111_0010_0;
   localparam logic [8:0] E_HALT  = 9'b1111_0011_0;
   localparam logic [8:0] E_ERR   = 9'b1111_0010_1;

   logic [8:0] exp_q[$];
   string      tag_q[$];

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .Instruction_IFID_IDEX  (inst_id),
      .Instruction_IDEX_EXMEM (inst_ex),
      .MemRead_IDEX_EXMEM     (mem_read),
      .branch_taken_EX        (br_taken),
      .dmem_req_MEM           (dmem_req),
      .dmem_ready             (dmem_ready),
      .halt_req               (halt_req),
      .stall_PC               (stall_PC),
      .stall_IFID             (stall_IFID),
      .stall_IDEX             (stall_IDEX),
      .stall_EXMEM            (stall_EXMEM),
      .flush_IFID             (flush_IFID),
      .flush_IDEX             (flush_IDEX),
      .flush_MEMWB            (flush_MEMWB),
      .halted                 (halted),
`ifdef HAZARD_PERF_CNT_EN
      .perf_loaduse_cnt       (perf_lu),
      .perf_memwait_cnt       (perf_mw),
      .perf_flush_cnt         (perf_br),
`endif
      .mem_timeout_err        (mem_timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
   endfunction

   // Inputs are already applied; push expectation, compare at negedge,
   // then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [8:0] exp);
      logic [8:0] e;
      string      t;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'({stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID,
                  flush_IDEX, flush_MEMWB, halted, mem_timeout_err}), 32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_id = 32'h0000_0013; inst_ex = 32'h0000_0013;
      mem_read = 0; br_taken = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      @(posedge clk); #1;
      cyc("reset0", E_RST);
      cyc("reset1", E_RST);
      rst_n = 1;
      cyc("idle", E_IDLE);

      // Load-use
      inst_ex = mk(5, 0, 0); mem_read = 1; inst_id = mk(6, 5, 1);
      cyc("lu_rs1", E_LU);
      mem_read = 0; inst_ex = 32'h13;
      cyc("lu_bubble", E_IDLE);
      inst_ex = mk(5, 0, 0); mem_read = 1; inst_id = mk(6, 1, 5);
      cyc("lu_rs2", E_LU);
      inst_id = mk(6, 7, 1);
      cyc("lu_nomatch", E_IDLE);
      inst_ex = mk(0, 0, 0); inst_id = mk(6, 0, 0);
      cyc("lu_x0", E_IDLE);

      // Branch overrides load-use
      inst_ex = mk(5, 0, 0); inst_id = mk(6, 5, 1); br_taken = 1;
      cyc("br_over_lu", E_BR);
      idle_inputs();

      // Memory wait, 3 low cycles; branch in the middle is ignored
      dmem_req = 1;
      cyc("mw0", E_STALL);
      br_taken = 1;
      cyc("mw1_br_ignored", E_STALL);
      br_taken = 0;
      cyc("mw2", E_STALL);
      dmem_ready = 1;
      cyc("mw_ready", E_IDLE);
      idle_inputs();
      cyc("mw_back_run", E_IDLE);

      // Halt pulse during memory wait
      dmem_req = 1;
      cyc("hmw0", E_STALL);
      halt_req = 1;
      cyc("hmw1", E_STALL);
      halt_req = 0;
      cyc("hmw2", E_STALL);
      dmem_ready = 1;
      cyc("hmw_ready", E_IDLE);
      idle_inputs();
      cyc("hmw_halted", E_HALT);
      cyc("hmw_run", E_IDLE);

      // Direct halt from RUN
      halt_req = 1;
      cyc("halt_enter", E_STALL);
      cyc("halt_hold", E_HALT);
      halt_req = 0;
      cyc("halt_release", E_HALT);
      cyc("halt_run", E_IDLE);

      // Reset discards a pending halt
      dmem_req = 1;
      cyc("rp0", E_STALL);
      halt_req = 1;
      cyc("rp1", E_STALL);
      halt_req = 0; rst_n = 0;
      cyc("rp_reset", E_RST);
      rst_n = 1; dmem_req = 0;
      cyc("rp_run", E_IDLE);

      // Timeout with MEM_TIMEOUT=4: RUN cycle + counter 1..4, then ERROR
      dmem_req = 1;
      for (int i = 0; i < 5; i++) cyc($sformatf("to_wait%0d", i), E_STALL);
      cyc("to_error", E_ERR);
      dmem_ready = 1;
      cyc("to_err_ready", E_ERR);
      idle_inputs();
      cyc("to_err_sticky", E_ERR);
      rst_n = 0;
      cyc("to_reset", E_RST | 9'b1);
      rst_n = 1;
      cyc("to_cleared", E_IDLE);

`ifdef HAZARD_PERF_CNT_EN
      rst_n = 0;
      cyc("perf_reset", E_RST);
      rst_n = 1;
      inst_ex = mk(5, 0, 0); mem_read = 1; inst_id = mk(6, 5, 1);
      cyc("perf_lu0", E_LU);
      cyc("perf_lu1", E_LU);
      idle_inputs();
      dmem_req = 1;
      cyc("perf_mw0", E_STALL);
      cyc("perf_mw1", E_STALL);
      cyc("perf_mw2", E_STALL);
      dmem_ready = 1;
      cyc("perf_mw_rdy", E_IDLE);
      idle_inputs();
      br_taken = 1;
      cyc("perf_br", E_BR);
      idle_inputs();
      cyc("perf_idle", E_IDLE);
      chk("perf_loaduse", perf_lu, 32'd2);
      chk("perf_memwait", perf_mw, 32'd3);
      chk("perf_flush", perf_br, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
